usb_cdc_send_buffer: RTL
========================

Name: usb_cdc_send_buffer

Overview:
- Parametrised N-channel device-to-host send buffer for USB CDC serial functions.
- Sits between user send ports (valid/ready per channel) and the IN-endpoint data ports of the USB full-speed core.
- Generalises the fixed 2-channel, 1024-byte buffers to NCH channels of configurable depth and byte width.
- Adds a full-latency output stage with sustained 1 byte/cycle throughput, per-channel fill level and almost-full flag, per-channel flush, and an optional drop-when-full mode with a drop counter.

Parameters:
- NCH, 2, number of independent channels (1..8).
- ASIZE, 10, log2 of per-channel buffer depth (depth = 2^ASIZE, ASIZE >= 2).
- DW, 8, data width per channel in bits.
- AFULL_TH, 768, level at or above which almost_full asserts (must be ≤ 2^ASIZE).
- DROP_WHEN_FULL, 0, 0: backpressure via send_ready; 1: send_ready held 1, bytes arriving when full are discarded and counted.

Ports:
- clk  input  1  system clock (60 MHz in the USB design).
- rstn  input  1  asynchronous active-low reset; all state clears while rstn=0.
- chan_clear  input  NCH  synchronous per-channel flush, bit i clears channel i.
- send_data  input  NCH*DW  write data; channel i at bits [i*DW +: DW].
- send_valid  input  NCH  write request per channel.
- send_ready  output  NCH  write accept per channel.
- in_data  output  NCH*DW  data toward IN endpoint; channel i at bits [i*DW +: DW].
- in_valid  output  NCH  in_data valid per channel.
- in_ready  input  NCH  endpoint accept per channel.
- level  output  NCH*(ASIZE+1)  bytes held in channel i, including the output register.
- almost_full  output  NCH  level ≥ AFULL_TH.
- drop_cnt  output  NCH*16  bytes discarded in drop mode; saturates at 16'hFFFF.

Behaviour:
- Reset (rstn=0, asynchronous): pointers=0; in_valid=0; level=0; almost_full=0; drop_cnt=0. send_ready=1 in both modes. in_data content is don't-care.
- Storage: one RAM of 2^ASIZE x DW per channel, inferable as BRAM (registered read). Pointers are ASIZE+1 bits. Full when pointers are equal except the MSB; empty when fully equal.
- Write: accepted at a rising edge when send_valid[i] & send_ready[i].
  - Backpressure mode: send_ready[i] = !full[i], combinational from registered pointers.
  - Drop mode: send_ready[i]=1 always. A valid byte arriving while full is not stored and increments drop_cnt[i] by 1, saturating.
- Read path: a prefetch stage feeds the output register (first-word-fall-through to the endpoint).
  - A byte accepted at edge E0 is visible with in_valid=1 after edge E2 when the channel was empty.
  - With in_ready held 1 and the buffer non-empty, one byte transfers every cycle with no bubbles.
  - in_data/in_valid hold stable while in_valid & !in_ready. No byte is duplicated or lost across a stall.
- Level: increments on an accepted write, decrements on an in_valid & in_ready handshake. Net 0 when both occur in the same cycle. Range 0..2^ASIZE.
  - The prefetch/output stages are counted within the 2^ASIZE capacity; they add no extra storage.
  - level and almost_full are registered and reflect edges up to and including the current one.
- chan_clear[i] (synchronous, one cycle): channel i pointers=0, level=0, in_valid deasserts the next cycle, drop_cnt[i]=0.
  - A write coinciding with clear is discarded. A handshake coinciding with clear completes and is not re-presented.
  - Other channels are unaffected.
- Channels are fully independent; simultaneous activity on all channels is legal.
- Wrap-around: pointers wrap modulo 2^(ASIZE+1). Data order is preserved across any number of wraps.
- Reset mid-transfer: everything clears immediately; in_valid drops asynchronously.

Test Plan:
- Latency: NCH=2, ASIZE=4. Write 0x41 on ch0 at cycle 0 with in_ready=1 → in_valid[0]=1 with in_data=0x41 after edge 2; level[0] reads 1 then 0.
- Full/backpressure: ASIZE=4, in_ready=0, write 20 bytes continuously → 16 accepted, send_ready=0 from the 17th. Release in_ready → bytes 0..15 in order; send_ready returns 1 after the first handshake.
- Drop mode: DROP_WHEN_FULL=1, ASIZE=4, in_ready=0, 20 bytes → drop_cnt=4, level=16. Drain yields the first 16 bytes only.
- Stall stability: stream 0x00..0xFF through ch1 while toggling in_ready pseudo-randomly → output sequence exactly 0x00..0xFF; in_data constant during every stall.
- Clear and independence: fill ch0 with 10 bytes and ch1 with 5, pulse chan_clear=2'b01 → level0=0 with no further in_valid[0]; ch1 still delivers its 5 bytes.
- Wrap and reset: 3×2^ASIZE+7 bytes with random in_ready → in-order, lossless. Assert rstn=0 mid-stream → in_valid=0 immediately; level=0 and drop_cnt=0.

Source files
------------

// File: rtl/usb_cdc_send_buffer.sv
// usb_cdc_send_buffer
// N-channel device-to-host byte buffer between user send ports and the
// IN-endpoint ports of a USB full-speed core. Each channel has a block-RAM
// FIFO, a prefetch register (the RAM's registered read port) and an output
// register. Together they give first-word-fall-through behaviour and
// sustained 1 byte/cycle throughput.
// Capacity is measured from the write pointer to a "handshake" pointer that
// advances only when the endpoint accepts a byte. Bytes sitting in the
// prefetch and output registers therefore still occupy their RAM slots.

module usb_cdc_send_buffer #(
    parameter int NCH            = 2,
    parameter int ASIZE          = 10,
    parameter int DW             = 8,
    parameter int AFULL_TH       = 768,
    parameter int DROP_WHEN_FULL = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NCH-1:0]           chan_clear,
    input  logic [NCH*DW-1:0]        send_data,
    input  logic [NCH-1:0]           send_valid,
    output logic [NCH-1:0]           send_ready,
    output logic [NCH*DW-1:0]        in_data,
    output logic [NCH-1:0]           in_valid,
    input  logic [NCH-1:0]           in_ready,
    output logic [NCH*(ASIZE+1)-1:0] level,
    output logic [NCH-1:0]           almost_full,
    output logic [NCH*16-1:0]        drop_cnt
);

    localparam int DEPTH = 1 << ASIZE;
    localparam int LW    = ASIZE + 1;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DW-1:0] mem [DEPTH];
        logic [LW-1:0] wptr;      // next slot to write
        logic [LW-1:0] rptr;      // next slot to fetch into the prefetch stage
        logic [LW-1:0] hptr;      // oldest slot not yet handed to the endpoint
        logic [LW-1:0] lvl;
        logic [LW-1:0] lvl_next;
        logic [DW-1:0] rd_data;   // prefetch stage data (RAM read register)
        logic [DW-1:0] out_data;
        logic          pf_valid;
        logic          out_valid;
        logic          afull;
        logic [15:0]   drops;
        logic          clr;
        logic          full;
        logic          wr_en;
        logic          drop_en;
        logic          hs;
        logic          pf_move;
        logic          rd_en;

        // Per-cycle control decisions for this channel.
        // NOTE: every signal is assigned on every pass through this block so no latch is inferred.
        always_comb begin
            clr      = chan_clear[i];
            full     = (wptr[ASIZE] != hptr[ASIZE]) &&
                       (wptr[ASIZE-1:0] == hptr[ASIZE-1:0]);
            wr_en    = send_valid[i] && !full && !clr;
            drop_en  = (DROP_WHEN_FULL != 0) && send_valid[i] && full && !clr;
            hs       = out_valid && in_ready[i];
            pf_move  = pf_valid && (!out_valid || in_ready[i]);
            rd_en    = (rptr != wptr) && (!pf_valid || pf_move) && !clr;
            lvl_next = lvl + LW'(wr_en) - LW'(hs);
        end

        // Storage and datapath registers; data only needs to be valid when
        // the matching valid flag is set.
        // NOTE: the RAM and data registers have no reset so the array maps onto block RAM.
        always_ff @(posedge clk) begin
            if (wr_en)   mem[wptr[ASIZE-1:0]] <= send_data[i*DW +: DW];
            if (rd_en)   rd_data <= mem[rptr[ASIZE-1:0]];
            if (pf_move) out_data <= rd_data;
        end

        // Pointers, stage valid flags, level, almost_full and drop counter.
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                wptr      <= '0;
                rptr      <= '0;
                hptr      <= '0;
                lvl       <= '0;
                pf_valid  <= 1'b0;
                out_valid <= 1'b0;
                afull     <= 1'b0;
                drops     <= '0;
            end else if (clr) begin
                wptr      <= '0;
                rptr      <= '0;
                hptr      <= '0;
                lvl       <= '0;
                pf_valid  <= 1'b0;
                out_valid <= 1'b0;
                afull     <= 1'b0;
                drops     <= '0;
            end else begin
                if (wr_en) wptr <= wptr + LW'(1);
                if (rd_en) rptr <= rptr + LW'(1);
                if (hs)    hptr <= hptr + LW'(1);

                if (rd_en)        pf_valid <= 1'b1;
                else if (pf_move) pf_valid <= 1'b0;

                if (pf_move)      out_valid <= 1'b1;
                else if (hs)      out_valid <= 1'b0;

                lvl   <= lvl_next;
                afull <= int'(lvl_next) >= AFULL_TH;

                if (drop_en && drops != 16'hFFFF) drops <= drops + 16'd1;
            end
        end

        assign send_ready[i]          = (DROP_WHEN_FULL != 0) ? 1'b1 : !full;
        assign in_data[i*DW +: DW]    = out_data;
        assign in_valid[i]            = out_valid;
        assign level[i*LW +: LW]      = lvl;
        assign almost_full[i]         = afull;
        assign drop_cnt[i*16 +: 16]   = drops;
    end

endmodule
